up_packet_bridge: RTL

UP_PACKET_BRIDGE -- requirements
Module: up_packet_bridge

---
 rtl/up_packet_bridge.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/up_packet_bridge.sv
// up_packet_bridge
//   Bridges a beat-serial microprocessor handshake port onto a single-cycle
//   register bus.
//   The uP sends a command packet with 2+DB beats:
//     - a command beat (bit0 = write, bit7 = soft reset),
//     - an address beat,
//     - DB data beats, least-significant beat first.
//   The bridge then runs one bus cycle, or a soft reset, and returns a reply
//   packet with 1+DB beats: a status beat followed by the read data.
//
// Ports
//   clk, reset          : clock (rising edge), asynchronous active-low reset
//   uP_start            : uP holds high for the whole transaction
//   uP_handshake_1      : uP beat strobe
//   uP_data_out         : command beat from the uP
//   uP_ack              : bridge owns the transaction
//   uP_handshake_2      : bridge beat acknowledge
//   uP_data_in          : reply beat to the uP
//   bus_handshake_1     : bus request
//   bus_handshake_2     : slave acknowledge
//   bus_rw              : 1 = write
//   bus_reg_address     : register address
//   bus_data_out        : write data to the bus
//   bus_data_in         : read data from the bus
//   soft_reset          : one-cycle pulse on a soft-reset command
module up_packet_bridge #(
  parameter int unsigned UP_WIDTH  = 8,
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uP_start,
  input  logic                 uP_handshake_1,
  input  logic [UP_WIDTH-1:0]  uP_data_out,
  output logic                 uP_ack,
  output logic                 uP_handshake_2,
  output logic [UP_WIDTH-1:0]  uP_data_in,
  output logic                 bus_handshake_1,
  input  logic                 bus_handshake_2,
  output logic                 bus_rw,
  output logic [7:0]           bus_reg_address,
  output logic [BUS_WIDTH-1:0] bus_data_out,
  input  logic [BUS_WIDTH-1:0] bus_data_in,
  output logic                 soft_reset
);

  localparam int unsigned DB   = BUS_WIDTH / UP_WIDTH;
  localparam int unsigned NCMD = 2 + DB;
  localparam int unsigned NREP = 1 + DB;
  localparam int unsigned CW   = $clog2(NCMD + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, RX_H, RX_L, BUS_REQ, BUS_REL, TX_H, TX_L, DONE
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [TW-1:0]        r_tcnt;
  logic                 r_ack;
  logic                 r_hs2;
  logic                 r_bus_req;
  logic                 r_soft;
  logic                 r_cmd_rw;
  logic                 r_cmd_sr;
  logic [7:0]           r_addr;
  logic [BUS_WIDTH-1:0] r_wdata;
  logic [BUS_WIDTH-1:0] r_rdata;
  logic [7:0]           r_status;
  logic [UP_WIDTH-1:0]  w_reply;

  // Only the command bits and the low address byte are ever used, so only
  // those are kept from the first two beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_ack     <= 1'b0;
      r_hs2     <= 1'b0;
      r_bus_req <= 1'b0;
      r_soft    <= 1'b0;
      r_cmd_rw  <= 1'b0;
      r_cmd_sr  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_status  <= '0;
    end else begin
      r_soft <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ack <= 1'b0;
          r_hs2 <= 1'b0;
          if (uP_start) begin
            r_state <= RX_H;
            r_ack   <= 1'b1;
            r_cnt   <= '0;
          end
        end
        RX_H: begin
          if (!uP_start) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_hs2   <= 1'b0;
          end else if (uP_handshake_1) begin
            if (r_cnt == '0) begin
              r_cmd_rw <= uP_data_out[0];
              r_cmd_sr <= uP_data_out[7];
            end else if (r_cnt == CW'(1)) begin
              r_addr <= uP_data_out[7:0];
            end
            for (int unsigned i = 0; i < DB; i++) begin
              if (r_cnt == CW'(i + 2)) r_wdata[i*UP_WIDTH +: UP_WIDTH] <= uP_data_out;
            end
            r_hs2   <= 1'b1;
            r_state <= RX_L;
          end
        end
        RX_L: begin
          if (!uP_start) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_hs2   <= 1'b0;
          end else if (!uP_handshake_1) begin
            r_hs2 <= 1'b0;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(NCMD - 1)) begin
              r_state   <= BUS_REQ;
              r_tcnt    <= '0;
              r_bus_req <= !r_cmd_sr;
            end else begin
              r_state <= RX_H;
            end
          end
        end
        BUS_REQ: begin
          if (r_cmd_sr) begin
            r_soft    <= 1'b1;
            r_status  <= 8'h80;
            r_cmd_rw  <= 1'b0;
            r_cmd_sr  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_bus_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= TX_H;
          end else if (bus_handshake_2) begin
            r_rdata   <= r_cmd_rw ? '0 : bus_data_in;
            r_status  <= 8'h00;
            r_bus_req <= 1'b0;
            r_state   <= BUS_REL;
          end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
            // The request was raised on entry, so this is its TIMEOUT-th cycle.
            r_rdata   <= '0;
            r_status  <= 8'h01;
            r_bus_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= TX_H;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        BUS_REL: begin
          if (!bus_handshake_2) begin
            r_cnt   <= '0;
            r_state <= TX_H;
          end
        end
        TX_H: begin
          if (!uP_start) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_hs2   <= 1'b0;
          end else if (uP_handshake_1) begin
            r_hs2   <= 1'b1;
            r_state <= TX_L;
          end
        end
        TX_L: begin
          if (!uP_start) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_hs2   <= 1'b0;
          end else if (!uP_handshake_1) begin
            r_hs2 <= 1'b0;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(NREP - 1)) begin
              r_state <= DONE;
              r_ack   <= 1'b0;
            end else begin
              r_state <= TX_H;
            end
          end
        end
        DONE: begin
          r_ack <= 1'b0;
          if (!uP_start) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Reply beat selected by the beat counter: status first, then read data.
  always_comb begin
    w_reply = '0;
    if (r_cnt == '0) w_reply[7:0] = r_status;
    for (int unsigned i = 0; i < DB; i++) begin
      if (r_cnt == CW'(i + 1)) w_reply = r_rdata[i*UP_WIDTH +: UP_WIDTH];
    end
  end

  assign uP_ack          = r_ack;
  assign uP_handshake_2  = r_hs2;
  assign uP_data_in      = (r_state == TX_H || r_state == TX_L) ? w_reply : '0;
  assign bus_handshake_1 = r_bus_req;
  assign bus_rw          = r_cmd_rw;
  assign bus_reg_address = r_addr;
  assign bus_data_out    = r_wdata;
  assign soft_reset      = r_soft;

endmodule
